// File: rtl/pc_word_pkg.sv
// Shared PC word definitions: field widths, word codes and serializer state encoding.
// Used by the FPGA-side serializer that feeds the PC-bound packer.
package pc_word_pkg;

   localparam int NPCcode      = 8;
   localparam int NPCdata      = 24;
   localparam int NTimeBits    = 48;
   localparam int NStateBits   = 27;
   localparam int NFiltIdxBits = 21;
   localparam int FILT_CODE    = 13;
   localparam int HB_CODE      = 14;

   typedef enum logic [NPCcode-1:0] {
      WC_FILT = NPCcode'(FILT_CODE),
      WC_HB   = NPCcode'(HB_CODE)
   } word_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HB_LO,
      ST_HB_HI,
      ST_FT_LO,
      ST_FT_HI
   } ser_state_t;

   typedef logic [NPCdata-1:0] payload_t;

   // Upper filter word: index on top, the state bits that spill past the low word below.
   function automatic payload_t ft_hi_payload(input logic [NStateBits-1:0]   st,
                                              input logic [NFiltIdxBits-1:0] idx);
      return {idx, st[NStateBits-1:NPCdata]};
   endfunction

endpackage

// File: rtl/fpga_serializer_if.sv
// Handshake bundle of the serializer: heartbeat and filter inputs, PC word output.
// master = the environment around the serializer, slave = the serializer itself.
interface fpga_serializer_if;
   import pc_word_pkg::*;

   logic                    hb_v;
   logic [NTimeBits-1:0]    hb_time;
   logic                    hb_a;
   logic                    filt_v;
   logic [NStateBits-1:0]   filt_state;
   logic [NFiltIdxBits-1:0] filt_idx;
   logic                    filt_a;
   logic                    out_v;
   logic [NPCcode-1:0]      out_code;
   logic [NPCdata-1:0]      out_payload;
   logic                    out_a;

   modport master (
      output hb_v, hb_time, filt_v, filt_state, filt_idx, out_a,
      input  hb_a, filt_a, out_v, out_code, out_payload
   );

   modport slave (
      input  hb_v, hb_time, filt_v, filt_state, filt_idx, out_a,
      output hb_a, filt_a, out_v, out_code, out_payload
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; req[0]=heartbeat, req[1]=filter.
// Grant bits never look at their own request, so accepts stay free of valid loops.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;  // 1: filter won the most recent tie

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
      end else if (advance && (&req)) begin
         last_grant <= grant[1];
      end
   end

   // A source is refused only when the other one requests and it holds priority.
   assign grant[0] = !(req[1] && !last_grant);
   assign grant[1] = !(req[0] &&  last_grant);

endmodule

// File: rtl/fpga_serializer.sv
// Serializes heartbeat times and filter events into pairs of PC words (LO then HI),
// keeping each pair contiguous and sustaining one word per cycle.
module fpga_serializer
   import pc_word_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   fpga_serializer_if.slave  bus
);

   ser_state_t         state, state_d;
   logic [NPCdata-1:0] cap_hi_p0, cap_hi_d;
   logic               out_v_d;
   logic [NPCcode-1:0] code_d;
   logic [NPCdata-1:0] payload_d;
   logic               cap_opp;
   logic               hb_xfer, ft_xfer;
   logic [1:0]         grant;

   // A new event may enter when nothing is in flight or its HI word leaves this cycle.
   assign cap_opp = (state == ST_IDLE) ||
                    (((state == ST_HB_HI) || (state == ST_FT_HI)) && bus.out_a);

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({bus.filt_v, bus.hb_v}),
      .advance (cap_opp),
      .grant   (grant)
   );

   assign bus.hb_a   = cap_opp && grant[0];
   assign bus.filt_a = cap_opp && grant[1];
   assign hb_xfer    = bus.hb_v   && bus.hb_a;
   assign ft_xfer    = bus.filt_v && bus.filt_a;

   always_comb begin
      state_d   = state;
      out_v_d   = bus.out_v;
      code_d    = bus.out_code;
      payload_d = bus.out_payload;
      cap_hi_d  = cap_hi_p0;
      if (cap_opp) begin
         if (hb_xfer) begin
            state_d   = ST_HB_LO;
            out_v_d   = 1'b1;
            code_d    = WC_HB;
            payload_d = bus.hb_time[NPCdata-1:0];
            cap_hi_d  = bus.hb_time[NTimeBits-1:NPCdata];
         end else if (ft_xfer) begin
            state_d   = ST_FT_LO;
            out_v_d   = 1'b1;
            code_d    = WC_FILT;
            payload_d = bus.filt_state[NPCdata-1:0];
            cap_hi_d  = ft_hi_payload(bus.filt_state, bus.filt_idx);
         end else begin
            state_d = ST_IDLE;
            out_v_d = 1'b0;
         end
      end else if (bus.out_a) begin
         case (state)
            ST_HB_LO: begin
               state_d   = ST_HB_HI;
               payload_d = cap_hi_p0;
            end
            ST_FT_LO: begin
               state_d   = ST_FT_HI;
               payload_d = cap_hi_p0;
            end
            default: ;
         endcase
      end
   end

   // Stage p0: captured HI chunk and registered output word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         bus.out_v       <= 1'b0;
         bus.out_code    <= '0;
         bus.out_payload <= '0;
         cap_hi_p0       <= '0;
      end else begin
         state           <= state_d;
         bus.out_v       <= out_v_d;
         bus.out_code    <= code_d;
         bus.out_payload <= payload_d;
         cap_hi_p0       <= cap_hi_d;
      end
   end

endmodule

// File: tb/tb_fpga_serializer.sv
// Scoreboard bench: accepted events are expanded into expected words by a transaction
// model; an output monitor pops and compares every word the serializer hands over.
module tb_fpga_serializer;
   import pc_word_pkg::*;

   typedef struct {
      logic [NPCcode-1:0] code;
      logic [NPCdata-1:0] payload;
      int                 cyc;
   } word_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fpga_serializer_if intf ();

   fpga_serializer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (intf)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int hb_rate  = 100;
   int ft_rate  = 100;
   int out_rate = 100;

   logic [47:0] hb_data_q[$];
   logic [47:0] ft_data_q[$];   // {idx, state}
   word_t       exp_q[$];
   word_t       log_q[$];

   logic hb_fire = 1'b0;
   logic ft_fire = 1'b0;
   logic last_ft = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic void push_word(input int code, input logic [NPCdata-1:0] pl);
      word_t w;
      w.code    = NPCcode'(code);
      w.payload = pl;
      w.cyc     = 0;
      exp_q.push_back(w);
   endfunction

   // Heartbeat source
   initial begin
      intf.hb_v    = 1'b0;
      intf.hb_time = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset) intf.hb_v = 1'b0;
         else if (intf.hb_v && hb_fire) intf.hb_v = 1'b0;
         if (reset && !intf.hb_v && hb_data_q.size() > 0 && $urandom_range(99) < hb_rate) begin
            intf.hb_time = hb_data_q.pop_front();
            intf.hb_v    = 1'b1;
         end
      end
   end

   // Filter source
   initial begin
      logic [47:0] d;
      intf.filt_v     = 1'b0;
      intf.filt_state = '0;
      intf.filt_idx   = '0;
      forever begin
         @(posedge clk); #1;
         if (!reset) intf.filt_v = 1'b0;
         else if (intf.filt_v && ft_fire) intf.filt_v = 1'b0;
         if (reset && !intf.filt_v && ft_data_q.size() > 0 && $urandom_range(99) < ft_rate) begin
            d               = ft_data_q.pop_front();
            intf.filt_idx   = d[47:27];
            intf.filt_state = d[26:0];
            intf.filt_v     = 1'b1;
         end
      end
   end

   // Sink
   initial begin
      intf.out_a = 1'b0;
      forever begin
         @(posedge clk); #1;
         intf.out_a = ($urandom_range(99) < out_rate);
      end
   end

   // Output monitor: the head of the expected queue must be on the bus whenever it exists
   always @(negedge clk) begin
      word_t w;
      if (!reset) begin
         chk("reset outputs", 64'({intf.out_v, intf.out_code, intf.out_payload}), 64'(0));
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         chk("out_v pending", 64'(intf.out_v), 64'(1));
         chk("word", 64'({intf.out_code, intf.out_payload}),
             64'({exp_q[0].code, exp_q[0].payload}));
         if (intf.out_v && intf.out_a) begin
            w.code    = intf.out_code;
            w.payload = intf.out_payload;
            w.cyc     = cyc;
            log_q.push_back(w);
            void'(exp_q.pop_front());
         end
      end else begin
         chk("out_v idle", 64'(intf.out_v), 64'(0));
      end
   end

   // Input monitor and reference model: an event may enter only once every expected
   // word has left (or leaves this cycle); ties alternate starting with heartbeat.
   initial begin
      logic e_hb, e_ft;
      forever begin
         @(negedge clk); #1;
         hb_fire = intf.hb_v && intf.hb_a;
         ft_fire = intf.filt_v && intf.filt_a;
         if (!reset) begin
            last_ft = 1'b1;
            hb_fire = 1'b0;
            ft_fire = 1'b0;
         end else begin
            e_hb = 1'b0;
            e_ft = 1'b0;
            if (exp_q.size() == 0) begin
               if (intf.hb_v && intf.filt_v) begin
                  e_hb    = last_ft;
                  e_ft    = !last_ft;
                  last_ft = e_ft;
               end else begin
                  e_hb = intf.hb_v;
                  e_ft = intf.filt_v;
               end
            end
            chk("accept {hb,ft}", 64'({hb_fire, ft_fire}), 64'({e_hb, e_ft}));
            if (e_hb) begin
               push_word(HB_CODE, intf.hb_time[23:0]);
               push_word(HB_CODE, intf.hb_time[47:24]);
            end
            if (e_ft) begin
               push_word(FILT_CODE, intf.filt_state[23:0]);
               push_word(FILT_CODE, {intf.filt_idx, intf.filt_state[26:24]});
            end
         end
      end
   end

   task automatic wait_idle(input int maxc, input string nm);
      int c = 0;
      while ((hb_data_q.size() > 0 || ft_data_q.size() > 0 || intf.hb_v || intf.filt_v ||
              exp_q.size() > 0) && c < maxc) begin
         @(posedge clk);
         c++;
      end
      repeat (3) @(posedge clk);
      chk({"drain ", nm}, 64'(c >= maxc), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] d;
      int          c;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;

      // Single heartbeat
      log_q.delete();
      hb_data_q.push_back(48'h123456_ABCDEF);
      wait_idle(50, "hb single");
      chk("hb single count", 64'(log_q.size()), 64'(2));
      if (log_q.size() == 2) begin
         chk("hb lo", 64'({log_q[0].code, log_q[0].payload}), 64'({8'd14, 24'hABCDEF}));
         chk("hb hi", 64'({log_q[1].code, log_q[1].payload}), 64'({8'd14, 24'h123456}));
      end

      // Single filter event
      log_q.delete();
      ft_data_q.push_back({21'h1F0F0, 27'h5ABCDEF});
      wait_idle(50, "ft single");
      chk("ft single count", 64'(log_q.size()), 64'(2));
      if (log_q.size() == 2) begin
         chk("ft lo", 64'({log_q[0].code, log_q[0].payload}), 64'({8'd13, 24'hABCDEF}));
         chk("ft hi", 64'({log_q[1].code, log_q[1].payload}), 64'({8'd13, 24'hF8785}));
      end

      // Both sources continuously valid
      log_q.delete();
      for (int i = 0; i < 4; i++) begin
         hb_data_q.push_back({$urandom, $urandom});
         ft_data_q.push_back({$urandom, $urandom});
      end
      wait_idle(100, "tie");
      chk("tie count", 64'(log_q.size()), 64'(16));
      if (log_q.size() == 16) begin
         for (int k = 0; k < 16; k++)
            chk("tie order code", 64'(log_q[k].code), 64'(((k / 2) % 2 == 0) ? 14 : 13));
         chk("tie back-to-back span", 64'(log_q[15].cyc - log_q[0].cyc), 64'(15));
      end

      // Random mix with backpressure
      log_q.delete();
      hb_rate  = 40;
      ft_rate  = 40;
      out_rate = 30;
      for (int i = 0; i < 50; i++) begin
         hb_data_q.push_back({$urandom, $urandom});
         ft_data_q.push_back({$urandom, $urandom});
      end
      wait_idle(6000, "random");
      chk("random count", 64'(log_q.size()), 64'(200));

      // Reset while a heartbeat HI word is pending
      hb_rate  = 100;
      ft_rate  = 100;
      out_rate = 0;
      hb_data_q.push_back({$urandom, $urandom});
      c = 0;
      while (exp_q.size() != 2 && c < 50) begin
         @(posedge clk); #2;
         c++;
      end
      chk("hb accepted before reset", 64'(exp_q.size()), 64'(2));
      out_rate = 100;
      @(posedge clk); #2;
      out_rate = 0;
      @(posedge clk); #3;
      chk("hb hi pending at reset", 64'(exp_q.size()), 64'(1));
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      out_rate = 100;
      log_q.delete();
      d = {$urandom, $urandom};
      ft_data_q.push_back(d);
      wait_idle(50, "post reset");
      chk("post reset count", 64'(log_q.size()), 64'(2));
      if (log_q.size() == 2) begin
         chk("post reset first lo", 64'({log_q[0].code, log_q[0].payload}),
             64'({8'd13, d[23:0]}));
         chk("post reset hi", 64'({log_q[1].code, log_q[1].payload}),
             64'({8'd13, d[47:27], d[26:24]}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
